wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
- Wishbone classic (B4, non-pipelined) initiator that turns single read/write commands from a valid/ready command port into bus cycles.
- Returns each result on a valid/ready response port.
- Drives the WB MI A slave side of the user project, e.g. the count-register block, from a local controller or LA-driven sequencer.
- Exactly one outstanding transaction; no bursts.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- SEL_W, DATA_W/8, byte-select width.
- TIMEOUT_CYCLES, 255, max cycles in REQ before abort (used only with the optional feature); range 1..65535.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_we  in  1  1=write, 0=read
- cmd_adr  in  ADDR_W  byte address
- cmd_dat  in  DATA_W  write data
- cmd_sel  in  SEL_W  byte enables
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_dat  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  bus error or timeout
- wbm_cyc_o  out  1  WB cycle
- wbm_stb_o  out  1  WB strobe
- wbm_we_o  out  1  WB write enable
- wbm_sel_o  out  SEL_W  WB byte select
- wbm_adr_o  out  ADDR_W  WB address
- wbm_dat_o  out  DATA_W  WB write data
- wbm_ack_i  in  1  WB acknowledge
- wbm_err_i  in  1  WB error termination
- wbm_dat_i  in  DATA_W  WB read data

Behaviour:
- All outputs registered. Reset values:
  - cmd_ready=0 during the reset cycle, then 1.
  - rsp_valid=0, rsp_err=0, rsp_dat=0.
  - cyc/stb/we=0, sel/adr/dat_o=0.
- FSM states IDLE, REQ, RSP; reset enters IDLE.
- IDLE:
  - cmd_ready=1.
  - On handshake at edge N: latch we/adr/dat/sel onto wbm_* outputs, set cyc=stb=1, cmd_ready=0, go to REQ.
  - Bus signals are visible from cycle N+1.
- REQ:
  - All wbm_* outputs held stable.
  - On an edge with ack_i=1: capture rsp_dat=(we?0:wbm_dat_i), rsp_err=0, drop cyc/stb/we, rsp_valid=1, go to RSP.
  - err_i=1 is handled identically except rsp_dat=0, rsp_err=1.
  - If ack and err are both high, err wins.
- Latency:
  - Combinational-ack slave: ack in cycle N+1, rsp_valid from N+2.
  - Registered-ack slave (acks one cycle after seeing stb): ack in N+2, rsp_valid from N+3.
- RSP:
  - rsp_* held stable while rsp_ready=0.
  - On handshake, rsp_valid=0, cmd_ready=1, go to IDLE.
  - No command is accepted in the same cycle as the response handshake; throughput is at most one transaction per 3 cycles.
- ack_i/err_i outside REQ are ignored (no state change, no error).
- Reset mid-transaction: at the reset edge cyc/stb drop immediately, any pending response is discarded, FSM returns to IDLE. The slave must tolerate the aborted cycle.
- cmd_* inputs are don't-care except in IDLE.

Optional Feature:
- Macro WB_CMD_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entering REQ and increments each REQ cycle without ack/err.
  - When it reaches TIMEOUT_CYCLES, cyc/stb drop at that edge and the FSM goes to RSP with rsp_err=1, rsp_dat=0.
  - An ack arriving on the same edge as the timeout wins (normal completion).
- Not defined:
  - No counter logic is instantiated.
  - REQ waits indefinitely for ack/err.

Decomposition:
- Package wb_cmd_master_pkg holds:
  - State enum {IDLE, REQ, RSP} (2-bit encoding).
  - Default widths ADDR_W_DEF=32, DATA_W_DEF=32.
  - TIMEOUT_W=16 counter width constant.
- Sub-module wb_timeout_ctr (clear, enable, limit → expired) is instantiated only under WB_CMD_MASTER_TIMEOUT_EN.

Test Plan:
1. Write then read through the count-register slave:
   - Stimulus: cmd we=1, adr=0x3000_0000, dat=0x1234_5678, sel=0xF; then a read with sel=0xF.
   - Response: write returns rsp_err=0, rsp_dat=0; the read returns 0x1234_5678 plus elapsed counts (the count register increments freely; check the value relative to the write).
2. Byte-lane write:
   - Stimulus: sel=0x2, dat=0x0000_AB00.
   - Response: wbm_sel_o=0x2 throughout the cycle; only bits [15:8] of the slave change.
3. Backpressure:
   - Stimulus: hold rsp_ready=0 for 5 cycles after rsp_valid.
   - Response: rsp_dat/rsp_err stable, cmd_ready=0, no new cyc; the FSM returns to IDLE one cycle after rsp_ready=1.
4. Error:
   - Stimulus: slave asserts err_i (with ack_i) in the first REQ cycle.
   - Response: rsp_err=1, rsp_dat=0, cyc low the next cycle.
5. Timeout (macro on, TIMEOUT_CYCLES=4):
   - Stimulus: slave never acks.
   - Response: cyc high for exactly 4 cycles, then rsp_err=1.
   - Macro off: cyc stays high for 100+ cycles.
6. Reset mid-REQ:
   - Stimulus: assert reset while cyc=1.
   - Response: cyc/stb=0 and rsp_valid=0 after that edge, cmd_ready=1 one cycle after reset deasserts; a stray ack afterwards is ignored.

Source files
------------

// File: rtl/wb_cmd_master_pkg.sv
// wb_cmd_master_pkg
// Shared definitions for the Wishbone command master slice.
//   state_e    : FSM state encoding (IDLE, REQ, RSP), 2 bits
//   *_DEF      : default address/data widths
//   TIMEOUT_W  : width of the optional REQ-phase timeout counter
package wb_cmd_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int TIMEOUT_W  = 16;

endpackage

// File: rtl/wb_cmd_master_if.sv
// wb_cmd_master_if
// Bundles the command port, response port and Wishbone initiator signals
// of wb_cmd_master.
//   modport master : the wb_cmd_master side (drives cmd_ready, rsp_*, wbm_*_o)
//   modport slave  : the environment side (command source, response sink,
//                    Wishbone target)
interface wb_cmd_master_if
  import wb_cmd_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = DATA_W / 8
);
  // command port
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_adr;
  logic [DATA_W-1:0] cmd_dat;
  logic [SEL_W-1:0]  cmd_sel;
  // response port
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_dat;
  logic              rsp_err;
  // Wishbone classic initiator
  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [SEL_W-1:0]  wbm_sel_o;
  logic [ADDR_W-1:0] wbm_adr_o;
  logic [DATA_W-1:0] wbm_dat_o;
  logic              wbm_ack_i;
  logic              wbm_err_i;
  logic [DATA_W-1:0] wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_err,
    input  rsp_ready,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_err_i, wbm_dat_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    output rsp_ready,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_err_i, wbm_dat_i
  );

endinterface

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr
// Counts cycles spent waiting for a bus termination.
//   clk, reset : clock, synchronous active-high reset
//   clear_i    : zero the count (held while not waiting)
//   enable_i   : one waiting cycle elapsed without termination
//   limit_i    : number of waiting cycles allowed
//   expired_o  : this enabled cycle is the limit-th one; abort at this edge
module wb_timeout_ctr
  import wb_cmd_master_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic [TIMEOUT_W-1:0] limit_i,
  output logic                 expired_o
);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed waiting cycles, so the current one is cnt_q+1.
  assign expired_o = enable_i && (cnt_q == limit_i - 1'b1);

endmodule

// File: rtl/wb_cmd_master.sv
// wb_cmd_master
// Wishbone classic (non-pipelined) initiator: one command accepted on the
// valid/ready command port becomes one bus cycle, and its result is returned
// on the valid/ready response port. One transaction outstanding at a time.
//   clk, reset : clock, synchronous active-high reset
//   bus        : wb_cmd_master_if.master (cmd_*, rsp_*, wbm_*)
// Optional build macro WB_CMD_MASTER_TIMEOUT_EN: abort a bus cycle with
// rsp_err=1 after TIMEOUT_CYCLES cycles without ack/err. When undefined the
// master waits indefinitely.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int SEL_W          = DATA_W / 8,
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic          clk,
  input  logic          reset,
  wb_cmd_master_if.master bus
);

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_o_q, dat_o_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
  logic              timeout;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TO_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

  wb_timeout_ctr u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_q != REQ),
    .enable_i  ((state_q == REQ) && !bus.wbm_ack_i && !bus.wbm_err_i),
    .limit_i   (TO_LIMIT),
    .expired_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_o_d     = dat_o_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;

    unique case (state_q)
      IDLE: begin
        // Raises cmd_ready on the first cycle after reset as well.
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          we_d        = bus.cmd_we;
          sel_d       = bus.cmd_sel;
          adr_d       = bus.cmd_adr;
          dat_o_d     = bus.cmd_dat;
          state_d     = REQ;
        end
      end
      REQ: begin
        // err takes priority over ack; a termination beats a same-edge timeout.
        if (bus.wbm_ack_i || bus.wbm_err_i || timeout) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
          if (bus.wbm_err_i || !bus.wbm_ack_i) begin
            rsp_err_d = 1'b1;
            rsp_dat_d = '0;
          end else begin
            rsp_err_d = 1'b0;
            rsp_dat_d = we_q ? '0 : bus.wbm_dat_i;
          end
        end
      end
      RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_o_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_o_q     <= dat_o_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = stb_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_o_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master
// Bench for wb_cmd_master: a Wishbone target (free-running count register at
// 0x3000_0000 plus a 16-word byte-lane memory) with selectable ack behaviour,
// a command driver, and a scoreboard monitor fed from a reference model.
module tb_wb_cmd_master;

  localparam logic [31:0] CNT_ADR = 32'h3000_0000;
  localparam logic [31:0] MEM_ADR = 32'h3000_0100;
  localparam int          TO_CYC  = 4;

  // slave behaviour per transaction
  localparam int M_ACK  = 0;  // combinational ack
  localparam int M_RACK = 1;  // ack one cycle after seeing stb
  localparam int M_ERR  = 2;  // err together with ack
  localparam int M_HANG = 3;  // never terminates

  typedef struct {
    logic [31:0] dat;
    logic        err;
    bit          cnt_rel;  // dat is a count-register base; add elapsed edges
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  wb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  logic [31:0] ref_mem [16];

  int          slv_mode = M_ACK;
  logic        force_ack = 1'b0;
  bit          bp_hold = 0, bp_force = 0, mon_off = 0;
  logic        cur_we;
  logic [31:0] cur_adr, cur_dat;
  logic [3:0]  cur_sel;
  int          cur_mode = M_ACK;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic int exp_len(input int mode);
    case (mode)
      M_RACK:  return 2;
      M_HANG:  return TO_CYC;
      default: return 1;
    endcase
  endfunction

  // ---------------- Wishbone target ----------------
  logic [31:0] mem [16];
  logic [31:0] cnt_q = 32'h0;
  logic        seen_q = 1'b0;
  int unsigned edge_n = 0, cnt_wr_edge = 0, cnt_rd_edge = 0;
  logic        s_req, s_ack, s_err, s_cnt;

  assign s_req = bus.wbm_cyc_o & bus.wbm_stb_o;
  assign s_cnt = (bus.wbm_adr_o == CNT_ADR);
  assign s_ack = force_ack | (s_req & ((slv_mode == M_ACK) | (slv_mode == M_ERR) |
                                       ((slv_mode == M_RACK) & seen_q)));
  assign s_err = s_req & (slv_mode == M_ERR);
  assign bus.wbm_ack_i = s_ack;
  assign bus.wbm_err_i = s_err;
  assign bus.wbm_dat_i = s_cnt ? cnt_q : mem[bus.wbm_adr_o[5:2]];

  initial for (int i = 0; i < 16; i++) begin mem[i] = '0; ref_mem[i] = '0; end

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    seen_q <= s_req & ~(s_ack | s_err);
    if (s_req & s_ack & ~s_err & bus.wbm_we_o & s_cnt) begin
      cnt_q       <= merge(cnt_q, bus.wbm_dat_o, bus.wbm_sel_o);
      cnt_wr_edge <= edge_n;
    end else begin
      cnt_q <= cnt_q + 1;
    end
    if (s_req & s_ack & ~s_err & ~bus.wbm_we_o & s_cnt) cnt_rd_edge <= edge_n;
    if (s_req & s_ack & ~s_err & bus.wbm_we_o & ~s_cnt)
      mem[bus.wbm_adr_o[5:2]] <= merge(mem[bus.wbm_adr_o[5:2]], bus.wbm_dat_o, bus.wbm_sel_o);
  end

  // ---------------- response sink ----------------
  always @(posedge clk) begin
    #2;
    bus.rsp_ready = bp_hold ? 1'b0 : (bp_force ? 1'b1 : ($urandom_range(0, 3) != 0));
  end

  // ---------------- monitor / scoreboard ----------------
  logic prev_cyc = 1'b0;
  int   cyc_run = 0;

  always @(negedge clk) begin
    if (reset || mon_off) begin
      prev_cyc = 1'b0;
      cyc_run  = 0;
    end else begin
      if (bus.wbm_cyc_o) begin
        cyc_run++;
        chk("bus_fields", {bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o},
            {1'b1, cur_we, cur_sel, cur_adr, cur_dat});
      end else if (prev_cyc) begin
        chk("cyc_len", 96'(cyc_run), 96'(exp_len(cur_mode)));
        chk("rsp_after_term", {95'd0, bus.rsp_valid}, 96'd1);
        cyc_run = 0;
      end
      prev_cyc = bus.wbm_cyc_o;
      if (bus.rsp_valid) begin
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", {95'd0, bus.rsp_valid}, 96'd0);
        end else begin
          exp_t        e;
          logic [31:0] ed;
          e  = sb_q[0];
          ed = e.cnt_rel ? e.dat + (cnt_rd_edge - 1 - cnt_wr_edge) : e.dat;
          chk("rsp_dat", {64'd0, bus.rsp_dat}, {64'd0, ed});
          chk("rsp_err", {95'd0, bus.rsp_err}, {95'd0, e.err});
          if (bus.rsp_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int mode, input bit push, input bit cnt_rel);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!bus.cmd_ready && waited < 300) begin @(negedge clk); waited++; end
    if (!bus.cmd_ready) begin
      n_vec++; n_bad++;
      $display("FAIL cmd_ready_wait: got 0 expected 1 within 300 cycles");
      return;
    end
    slv_mode  = mode;
    e.cnt_rel = cnt_rel;
    e.err     = (mode >= M_ERR);
    e.dat     = cnt_rel ? dat : 32'h0;
    if (mode < M_ERR && adr != CNT_ADR) begin
      if (we) ref_mem[adr[5:2]] = merge(ref_mem[adr[5:2]], dat, sel);
      else    e.dat = ref_mem[adr[5:2]];
    end
    if (push) sb_q.push_back(e);
    cur_we = we; cur_adr = adr; cur_dat = dat; cur_sel = sel; cur_mode = mode;
    bus.cmd_valid = 1'b1;
    bus.cmd_we = we; bus.cmd_adr = adr; bus.cmd_dat = dat; bus.cmd_sel = sel;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we  = 1'($urandom);
    bus.cmd_adr = $urandom;
    bus.cmd_dat = $urandom;
    bus.cmd_sel = 4'($urandom);
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((sb_q.size() != 0 || bus.rsp_valid) && waited < 500) begin
      @(negedge clk); waited++;
    end
    chk("drain", 96'(sb_q.size()), 96'd0);
  endtask

  // Abort the bus cycle in flight with reset, then throw a stray ack at IDLE.
  task automatic abort_reset();
    @(negedge clk);
    chk("cyc_before_reset", {95'd0, bus.wbm_cyc_o}, 96'd1);
    mon_off = 1;
    reset   = 1'b1;
    @(negedge clk);
    chk("reset_abort", {92'd0, bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid, bus.cmd_ready}, 96'd0);
    sb_q.delete();
    reset     = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {95'd0, bus.cmd_ready}, 96'd1);
    @(negedge clk);
    chk("stray_ack", {93'd0, bus.wbm_cyc_o, bus.rsp_valid, bus.cmd_ready}, 96'd1);
    force_ack = 1'b0;
    mon_off   = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_adr = '0; bus.cmd_dat = '0; bus.cmd_sel = '0;
    bus.rsp_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {90'd0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.wbm_cyc_o,
                       bus.wbm_stb_o, bus.wbm_we_o}, 96'd0);
    chk("reset_data", {bus.rsp_dat, bus.wbm_adr_o, bus.wbm_dat_o}, 96'd0);
    chk("reset_sel", {92'd0, bus.wbm_sel_o}, 96'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_init", {95'd0, bus.cmd_ready}, 96'd1);

    // write then read the free-running count register
    issue(1'b1, CNT_ADR, 32'h1234_5678, 4'hF, M_ACK, 1, 0);
    issue(1'b0, CNT_ADR, 32'h1234_5678, 4'hF, M_ACK, 1, 1);
    drain();

    // byte-lane write into memory word 1, then read back
    issue(1'b1, MEM_ADR + 32'd4, 32'h1122_3344, 4'hF, M_ACK, 1, 0);
    issue(1'b1, MEM_ADR + 32'd4, 32'h0000_AB00, 4'h2, M_RACK, 1, 0);
    issue(1'b0, MEM_ADR + 32'd4, 32'h0, 4'hF, M_ACK, 1, 0);
    drain();

    // backpressure: hold rsp_ready low for 5 cycles after rsp_valid
    bp_hold = 1;
    issue(1'b0, MEM_ADR + 32'd4, 32'h0, 4'hF, M_ACK, 1, 0);
    waited = 0;
    while (!bus.rsp_valid && waited < 20) begin @(negedge clk); waited++; end
    chk("bp_rsp_seen", {95'd0, bus.rsp_valid}, 96'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold", {93'd0, bus.cmd_ready, bus.wbm_cyc_o, bus.rsp_valid}, 96'd1);
    end
    bp_hold  = 0;
    bp_force = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release", {94'd0, bus.rsp_valid, bus.cmd_ready}, 96'd1);
    bp_force = 0;

    // error termination (err and ack together)
    issue(1'b0, MEM_ADR + 32'd4, 32'h0, 4'hF, M_ERR, 1, 0);
    issue(1'b1, MEM_ADR + 32'd8, 32'hDEAD_BEEF, 4'hF, M_ERR, 1, 0);
    issue(1'b0, MEM_ADR + 32'd8, 32'h0, 4'hF, M_ACK, 1, 0);
    drain();

    // unresponsive slave
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    issue(1'b0, MEM_ADR, 32'h0, 4'hF, M_HANG, 1, 0);
    drain();
`else
    issue(1'b0, MEM_ADR, 32'h0, 4'hF, M_HANG, 0, 0);
    waited = 0;
    repeat (110) begin @(negedge clk); if (bus.wbm_cyc_o) waited++; end
    chk("no_timeout", 96'(waited), 96'd110);
    abort_reset();
`endif

    // reset in the middle of REQ
    issue(1'b1, MEM_ADR + 32'd12, 32'hCAFE_F00D, 4'hF, M_HANG, 0, 0);
    abort_reset();

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      logic [3:0] s;
      s = 4'($urandom_range(1, 15));
      issue(1'($urandom), MEM_ADR + 32'($urandom_range(0, 15)) * 4, $urandom, s,
            $urandom_range(0, 2), 1, 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
